// File: rtl/neuron_pkg.sv
// neuron_pkg: shared neuron-datapath types, default widths and accumulator width helper.
package neuron_pkg;

    typedef enum logic {ACCUM, HOLD} accum_state_e;

    localparam int NEURON_IN_W      = 17;
    localparam int NEURON_BIAS_W    = 8;
    localparam int NEURON_NUM_TERMS = 4;
    localparam int NEURON_OUT_W     = 18;

    // Wide enough for NUM_TERMS terms plus the bias without wrapping.
    function automatic int acc_width(input int in_w, input int bias_w, input int n);
        return ((in_w > bias_w) ? in_w : bias_w) + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/neuron_accum_sat_narrow.sv
// sat_narrow: combinational ACC_W->OUT_W signed reduction with overflow flag.
// Ports: acc_i (full-precision value), sum_o (narrowed value), ovf_o (value not representable).
// NEURON_ACCUM_SATURATE_EN: clamp on overflow instead of two's-complement wrap.
module sat_narrow #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 18
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] sum_o,
    output logic                    ovf_o
);
    if (ACC_W > OUT_W) begin : g_narrow
        // Representable only when every bit from the OUT_W sign bit upward agrees.
        logic [ACC_W-OUT_W:0] top;
        assign top   = acc_i[ACC_W-1:OUT_W-1];
        assign ovf_o = !(&top || ~|top);
`ifdef NEURON_ACCUM_SATURATE_EN
        assign sum_o = !ovf_o        ? acc_i[OUT_W-1:0] :
                       acc_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                        {1'b0, {(OUT_W-1){1'b1}}};
`else
        assign sum_o = acc_i[OUT_W-1:0];
`endif
    end else begin : g_wide
        assign sum_o = OUT_W'(acc_i);
        assign ovf_o = 1'b0;
    end
endmodule

// File: rtl/neuron_accum.sv
// neuron_accum: NUM_TERMS-term signed accumulator with bias, registered narrowed sum and overflow flag.
// Ports: clk, rst_n (async active-low), clr (sync frame abort),
//        in_valid/in_ready/in_data/bias (term stream, bias taken on first beat),
//        out_valid/out_ready/out_sum/out_ovf (held result).
// NEURON_ACCUM_SATURATE_EN selects clamping in sat_narrow; out_ovf is unaffected.
module neuron_accum
    import neuron_pkg::*;
#(
    parameter int IN_W      = NEURON_IN_W,
    parameter int BIAS_W    = NEURON_BIAS_W,
    parameter int NUM_TERMS = NEURON_NUM_TERMS,
    parameter int OUT_W     = NEURON_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_data,
    input  logic signed [BIAS_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_sum,
    output logic                     out_ovf
);
    localparam int ACC_W = acc_width(IN_W, BIAS_W, NUM_TERMS);
    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    if (NUM_TERMS < 1) begin : g_bad_num_terms
        $error("neuron_accum: NUM_TERMS must be >= 1");
    end

    accum_state_e             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_sum_q, out_sum_d;
    logic                     out_ovf_q, out_ovf_d;
    logic                     beat, last;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [OUT_W-1:0]  nar_sum;
    logic                     nar_ovf;

    assign beat    = in_valid && in_ready;
    assign last    = beat && (cnt_q == LAST);
    // The first beat seeds the accumulator with the bias instead of the stale sum.
    assign acc_sum = ((cnt_q == '0) ? ACC_W'(bias) : acc_q) + ACC_W'(in_data);

    sat_narrow #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_narrow (
        .acc_i (acc_sum),
        .sum_o (nar_sum),
        .ovf_o (nar_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // HOLD always has out_valid set, so out_ready alone completes the handshake.
    always_comb begin
        state_d     = clr ? ACCUM :
                      (state_q == ACCUM) ? (last ? HOLD : ACCUM) :
                      (out_ready ? ACCUM : HOLD);
        cnt_d       = clr ? '0 : beat ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        acc_d       = clr ? '0 : beat ? acc_sum : acc_q;
        out_valid_d = clr ? 1'b0 : last ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        out_sum_d   = (last && !clr) ? nar_sum : out_sum_q;
        out_ovf_d   = (last && !clr) ? nar_ovf : out_ovf_q;
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = out_valid_q;
        out_sum   = out_sum_q;
        out_ovf   = out_ovf_q;
    end
endmodule

// File: tb/tb_neuron_accum.sv
// tb_neuron_accum: directed scoreboard bench for neuron_accum at default parameters.
module tb_neuron_accum;
    localparam longint HMAX = 131071;
    localparam longint HMIN = -131072;

    typedef struct {
        longint sum;
        longint ovf;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic               in_ready;
    logic signed [16:0] in_data;
    logic signed [7:0]  bias;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_sum;
    logic               out_ovf;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    neuron_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One beat, driven and sampled on negedges; bias is randomised on non-first beats.
    task automatic beat(input longint d, input longint b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 17'(d);
        bias     = 8'(b);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_wait_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        bias     = 8'($urandom);
    endtask

    task automatic frame(input longint a, input longint b, input longint c, input longint d,
                         input longint bs, input int gap);
        longint full;
        exp_t   e;
        logic signed [17:0] w;
        full  = bs + a + b + c + d;
        e.ovf = (full > HMAX || full < HMIN) ? 1 : 0;
`ifdef NEURON_ACCUM_SATURATE_EN
        e.sum = (full > HMAX) ? HMAX : (full < HMIN) ? HMIN : full;
`else
        w     = full[17:0];
        e.sum = w;
`endif
        q.push_back(e);
        beat(a, bs);
        repeat (gap) @(negedge clk);
        beat(b, $urandom);
        repeat (gap) @(negedge clk);
        beat(c, $urandom);
        repeat (gap) @(negedge clk);
        beat(d, $urandom);
    endtask

    task automatic expect_result(input string tag, input bit immediate);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        if (immediate) chk({tag, "_latency"}, n, 0);
        if (q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, q.size(), 1);
        end else begin
            e = q.pop_front();
            chk({tag, "_sum"}, out_sum, e.sum);
            chk({tag, "_ovf"}, out_ovf, e.ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_clear"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        bias      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);

        frame(100, 200, -50, 7, -3, 0);
        expect_result("basic", 1'b1);

        frame(10, 20, 30, 40, 0, 0);
        in_valid = 1'b1;
        in_data  = 17'sd999;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_sum", out_sum, 100);
        end
        in_valid = 1'b0;
        expect_result("bp_held", 1'b0);
        frame(1, 1, 1, 1, 0, 0);
        expect_result("bp_next", 1'b1);

        frame(65535, 65535, 65535, 65535, 127, 0);
        expect_result("pos_ovf", 1'b1);
        frame(-65536, -65536, -65536, -65536, -128, 0);
        expect_result("neg_ovf", 1'b1);

        beat(9, 50);
        beat(9, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_valid", out_valid, 0);
        frame(5, 5, 5, 5, 1, 0);
        expect_result("after_clr", 1'b1);

        beat(9, 50);
        beat(9, 0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 17'sd100;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        frame(5, 5, 5, 5, 1, 0);
        expect_result("after_clr_beat", 1'b1);

        beat(9, 50);
        beat(9, 0);
        beat(9, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(5, 5, 5, 5, 1, 2);
        expect_result("after_rst_gaps", 1'b1);

        frame(3, 4, 5, 6, 7, 0);
        chk("clr_hold_valid_before", out_valid, 1);
        clr       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        out_ready = 1'b0;
        chk("clr_hold_valid", out_valid, 0);
        chk("clr_hold_in_ready", in_ready, 1);
        void'(q.pop_front());

        repeat (3) begin
            frame(longint'($urandom_range(0, 131071)) - 65536,
                  longint'($urandom_range(0, 131071)) - 65536,
                  longint'($urandom_range(0, 131071)) - 65536,
                  longint'($urandom_range(0, 131071)) - 65536,
                  longint'($urandom_range(0, 255)) - 128, $urandom_range(0, 2));
            expect_result("random", 1'b1);
        end

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_accum.md
# neuron_accum

Parametrised multi-term signed accumulator for the neuron datapath. Accepts a frame of `NUM_TERMS` signed weighted-input terms over a valid/ready stream. Adds a signed bias sampled with the first term, and presents one registered, width-reduced sum with an overflow flag. It replaces the fixed two-operand adder between the multiplier stage and the activation stage.

## Interface
Parameters:
- `IN_W`, 17, signed width of each term
- `BIAS_W`, 8, signed width of bias
- `NUM_TERMS`, 4, terms per frame; must be ≥1, elaboration error otherwise
- `OUT_W`, 18, signed width of the presented sum

Ports:
- `clk` in 1 — the block's only clock, rising edge
- `rst_n` in 1 — asynchronous assert, active-low reset; released synchronously by the reset tree
- `clr` in 1 — synchronous frame abort
- `in_valid` in 1 — term valid
- `in_ready` out 1 — block can accept a term
- `in_data` in `IN_W` — signed term
- `bias` in `BIAS_W` — signed bias, sampled on the first beat of each frame
- `out_valid` out 1 — result valid
- `out_ready` in 1 — consumer accepts the result
- `out_sum` out `OUT_W` — signed result
- `out_ovf` out 1 — full-precision result not representable in `OUT_W`

## Operation
- **Internal accumulator width:** `ACC_W = max(IN_W,BIAS_W) + $clog2(NUM_TERMS+1)`. All operands are sign-extended to `ACC_W`, so the accumulator never wraps internally.
- **Beat:** a beat is a cycle with `in_valid && in_ready`.
- **States:** `ACCUM` (reset state) and `HOLD`.
- **`ACCUM`:**
  - `in_ready=1`.
  - Beat with `cnt==0`: `acc <= sext(bias) + sext(in_data)`.
  - Later beats: `acc <= acc + sext(in_data)`.
  - `cnt` increments on each beat.
  - The beat with `cnt==NUM_TERMS-1`:
    - registers `out_sum` and `out_ovf` from the final full-precision value;
    - sets `out_valid`, clears `cnt`, and enters `HOLD`.
  - For `NUM_TERMS==1` the first beat is also the last.
- **`HOLD`:**
  - `in_ready=0`; `in_valid` is ignored.
  - `out_sum`, `out_ovf` and `out_valid` are held stable.
  - `out_valid && out_ready` clears `out_valid` and returns to `ACCUM`.
- **Width reduction:** `out_ovf=1` when the final value is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]. `out_sum` mapping: see Configuration.
- **`clr`:**
  - Forces `cnt=0`, `acc=0`, `out_valid=0`, and state `ACCUM`.
  - Has priority over a beat or handshake in the same cycle; that beat is discarded.
- **`rst_n` low, at any time including mid-frame:** all state returns to reset values immediately and the partial frame is lost.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_ovf=0`, `cnt=0`, `acc=0`, state `ACCUM`.
- Latency: `out_valid` rises on the clock edge that captures the last beat, so it is visible in the following cycle.
- Throughput: at most one frame per `NUM_TERMS+1` cycles with `out_ready` held high. There is no overlap of the `HOLD` cycle with the next frame.
- `in_ready` is a registered-state decode only, with no combinational path from `out_ready`.
- Terms may arrive with arbitrary gaps; `cnt` advances only on beats.
- `bias` changes after the first beat have no effect on that frame.

## Configuration
- `NEURON_ACCUM_SATURATE_EN` defined:
  - `out_sum` clamps to `2^(OUT_W-1)-1` on positive overflow and to `-2^(OUT_W-1)` on negative overflow.
  - Otherwise it passes the value unchanged.
- Not defined: `out_sum = acc_final[OUT_W-1:0]` (two's-complement wrap).
- `out_ovf` behaves identically in both builds.

## Structure
- Shared package `neuron_pkg`:
  - state enum `accum_state_e` (`ACCUM`, `HOLD`);
  - function `acc_width(in_w, bias_w, n)`;
  - constants for the default widths used across the neuron datapath.
- One sub-module, `sat_narrow`:
  - combinational `ACC_W`→`OUT_W` reduction producing the narrowed value and the overflow flag;
  - contains the `NEURON_ACCUM_SATURATE_EN` branch.

## Test plan
All scenarios use default parameters.
- **Reset:** assert `rst_n` low, then release → `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_ovf=0`.
- **Basic frame:** terms 100, 200, -50, 7 with bias -3 → `out_sum=254`, `out_ovf=0`, `out_valid` high the cycle after the 4th beat.
- **Backpressure:**
  - hold `out_ready=0` for 5 cycles while driving `in_valid=1` → `out_sum` stable, `in_ready=0`, no terms absorbed;
  - then raise `out_ready` → the next frame 1, 1, 1, 1 with bias 0 yields 4.
- **Positive overflow:** four terms of 65535, bias 127 (full value 262267):
  - without the macro → `out_sum=123`, `out_ovf=1`;
  - with `NEURON_ACCUM_SATURATE_EN` → `out_sum=131071`, `out_ovf=1`.
- **Negative overflow:** four terms of -65536, bias -128:
  - without the macro → `out_sum=-128`, `out_ovf=1`;
  - with the macro → `out_sum=-131072`.
- **Abort mid-frame:** send 2 beats, then `clr` (once with a coincident beat); separately, pulse `rst_n` low after 3 beats. In each case a following frame 5, 5, 5, 5 with bias 1 → `out_sum=21`, with no contribution from the aborted terms.
